// File: rtl/drop_verdict_gate_pkg.sv
// Shared definitions for the drop verdict gate: FSM encoding, verdict bit
// positions and the saturation ceiling of the statistics counters.
package drop_verdict_gate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_PASS = 2'd2,
    ST_DROP = 2'd3
  } gate_state_t;

  // Verdict vector bit positions.
  localparam int VERDICT_CSUM = 0;
  localparam int VERDICT_MAC0 = 1;
  localparam int VERDICT_MAC1 = 2;
  localparam int VERDICT_MAC2 = 3;
  localparam int VERDICT_MAC3 = 4;

  localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/drop_verdict_gate_sat_counter32.sv
// 32-bit event counter that sticks at its maximum value. Clear wins over
// increment so software always observes a zero after clearing.
module sat_counter32
  import drop_verdict_gate_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] value
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Next count: clear first, otherwise increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != SAT_MAX)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;

endmodule

// File: rtl/drop_verdict_gate.sv
// Packet-level forward/discard gate. The head beat of each packet is held
// upstream until a drop verdict (or a timeout) decides the fate of the whole
// packet; the payload then streams through or is silently absorbed.
module drop_verdict_gate
  import drop_verdict_gate_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int VERDICT_WIDTH      = 5,
  parameter int TIMEOUT_CYCLES     = 64,
  parameter int DEFAULT_DROP       = 1
) (
  input  logic                            AXI_ACLK,
  input  logic                            AXI_RESET,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                            S_AXIS_TVALID,
  output logic                            S_AXIS_TREADY,
  input  logic                            S_AXIS_TLAST,
  output logic [C_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  output logic                            M_AXIS_TLAST,
  input  logic                            verdict_valid,
  input  logic [VERDICT_WIDTH-1:0]        verdict,
  output logic                            verdict_ack,
  input  logic [VERDICT_WIDTH-1:0]        drop_mask,
  input  logic                            counters_clear,
  output logic [31:0]                     forwarded_count,
  output logic [31:0]                     discarded_count,
  output logic [31:0]                     timeout_count,
  output logic [VERDICT_WIDTH-1:0]        last_drop_reason
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam bit DFLT_DROP = (DEFAULT_DROP != 0);

  gate_state_t              state_q, state_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic [VERDICT_WIDTH-1:0] reason_q, reason_d;
  logic [VERDICT_WIDTH-1:0] masked_verdict;
  logic                     fwd_inc, dis_inc, tmo_inc;

  // Payload and sideband are never stored; only the handshake is gated.
  assign M_AXIS_TDATA = S_AXIS_TDATA;
  assign M_AXIS_TSTRB = S_AXIS_TSTRB;
  assign M_AXIS_TUSER = S_AXIS_TUSER;
  assign M_AXIS_TLAST = S_AXIS_TLAST;

  assign masked_verdict = verdict & drop_mask;

  // Decision FSM: next state, handshake gating, ack and counter events.
  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    reason_d      = reason_q;
    fwd_inc       = 1'b0;
    dis_inc       = 1'b0;
    tmo_inc       = 1'b0;
    verdict_ack   = 1'b0;
    S_AXIS_TREADY = 1'b0;
    M_AXIS_TVALID = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (S_AXIS_TVALID) begin
          state_d = ST_WAIT;
          tmo_d   = '0;
        end
      end
      ST_WAIT: begin
        // A verdict present in the timeout cycle takes precedence.
        if (verdict_valid) begin
          verdict_ack = 1'b1;
          if (|masked_verdict) begin
            state_d  = ST_DROP;
            reason_d = masked_verdict;
          end else begin
            state_d = ST_PASS;
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_inc = 1'b1;
          state_d = DFLT_DROP ? ST_DROP : ST_PASS;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_PASS: begin
        M_AXIS_TVALID = S_AXIS_TVALID;
        S_AXIS_TREADY = M_AXIS_TREADY;
        if (S_AXIS_TVALID && M_AXIS_TREADY && S_AXIS_TLAST) begin
          fwd_inc = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        S_AXIS_TREADY = 1'b1;
        if (S_AXIS_TVALID && S_AXIS_TLAST) begin
          dis_inc = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (counters_clear) begin
      reason_d = '0;
    end
  end

  // State, timeout counter and last-drop-reason registers.
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      state_q  <= ST_IDLE;
      tmo_q    <= '0;
      reason_q <= '0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      reason_q <= reason_d;
    end
  end

  assign last_drop_reason = reason_q;

  sat_counter32 u_fwd_cnt (
    .clk   (AXI_ACLK),
    .rst   (AXI_RESET),
    .clr   (counters_clear),
    .inc   (fwd_inc),
    .value (forwarded_count)
  );

  sat_counter32 u_dis_cnt (
    .clk   (AXI_ACLK),
    .rst   (AXI_RESET),
    .clr   (counters_clear),
    .inc   (dis_inc),
    .value (discarded_count)
  );

  sat_counter32 u_tmo_cnt (
    .clk   (AXI_ACLK),
    .rst   (AXI_RESET),
    .clr   (counters_clear),
    .inc   (tmo_inc),
    .value (timeout_count)
  );

endmodule
